// File: rtl/pcie_tx_pkg.sv
// Shared PCIe TX-path definitions: symbol constants, the SKP ordered-set beat,
// the packet-tracking state type and the PIPE width encodings.
package pcie_tx_pkg;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;

  // One 4-symbol beat carrying COM SKP SKP SKP, with byte0 as the first symbol.
  localparam logic [31:0] SKP_OS_DATA  = {SKP, SKP, SKP, COM};
  localparam logic [3:0]  SKP_OS_DATAK = 4'hF;

  typedef enum logic {
    BOUNDARY,
    IN_PKT
  } tx_state_e;

  typedef enum logic [1:0] {
    PIPE_W8  = 2'b00,
    PIPE_W16 = 2'b01,
    PIPE_W32 = 2'b10
  } pipe_width_e;

  localparam pipe_width_e TX_PIPE_WIDTH = PIPE_W32;

endpackage

// File: rtl/skp_interval_timer.sv
// Symbol-time interval counter that accumulates owed SKP ordered sets in a
// saturating pending counter and flags an interval lost to saturation.
module skp_interval_timer #(
  parameter int SKP_INTERVAL_BEATS = 295,
  parameter int MAX_PENDING        = 3,
  parameter int PENDING_W          = $clog2(MAX_PENDING + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 skp_taken,
  output logic [PENDING_W-1:0] pending,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(SKP_INTERVAL_BEATS);

  logic [CNT_W-1:0]     beat_cnt;
  logic                 tick;
  logic [PENDING_W-1:0] pending_dec;
  logic                 saturated;

  assign tick        = enable && (beat_cnt == CNT_W'(SKP_INTERVAL_BEATS - 1));
  // Saturation is judged after this cycle's insertion, so a tick that lands
  // on an insertion simply replaces the SKP being sent.
  assign pending_dec = pending - PENDING_W'(skp_taken);
  assign saturated   = (pending_dec == PENDING_W'(MAX_PENDING));

  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      beat_cnt <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      beat_cnt <= tick ? '0 : beat_cnt + 1'b1;
      overflow <= tick && saturated;
      pending  <= (tick && !saturated) ? pending_dec + 1'b1 : pending_dec;
    end
  end

endmodule

// File: rtl/tx_skp_scheduler.sv
// Places SKP ordered sets between packets on the 4-symbol TX datapath,
// stalling upstream for each inserted beat.
module tx_skp_scheduler
  import pcie_tx_pkg::*;
#(
  parameter int SKP_INTERVAL_BEATS = 295,
  parameter int MAX_PENDING        = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_datak,
  input  logic        in_valid,
  input  logic        in_eop,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_datak,
  output logic        out_valid,
  output logic        skp_sent,
  output logic        skp_overflow
);

  localparam int PW = $clog2(MAX_PENDING + 1);

  tx_state_e     state;
  tx_state_e     state_next;
  logic [PW-1:0] pending;
  logic          insert;
  logic          accept;

  skp_interval_timer #(
    .SKP_INTERVAL_BEATS(SKP_INTERVAL_BEATS),
    .MAX_PENDING       (MAX_PENDING),
    .PENDING_W         (PW)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .skp_taken(insert),
    .pending  (pending),
    .overflow (skp_overflow)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= BOUNDARY;
    end else begin
      state <= state_next;
    end
  end

  // Insertion only ever happens with no packet open, so packets are never split.
  always_comb begin
    state_next = state;
    insert     = 1'b0;
    in_ready   = 1'b1;
    case (state)
      BOUNDARY: begin
        if (enable && (pending != '0)) begin
          insert   = 1'b1;
          in_ready = 1'b0;
        end else if (in_valid && !in_eop) begin
          state_next = IN_PKT;
        end
      end
      IN_PKT: begin
        if (in_valid && in_eop) begin
          state_next = BOUNDARY;
        end
      end
      default: state_next = BOUNDARY;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_datak <= '0;
      out_valid <= 1'b0;
      skp_sent  <= 1'b0;
    end else if (insert) begin
      out_data  <= SKP_OS_DATA;
      out_datak <= SKP_OS_DATAK;
      out_valid <= 1'b1;
      skp_sent  <= 1'b1;
    end else if (accept) begin
      out_data  <= in_data;
      out_datak <= in_datak;
      out_valid <= 1'b1;
      skp_sent  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      skp_sent  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_skp_scheduler.sv
// Directed bench for tx_skp_scheduler with an 8-beat SKP interval; every
// expectation is a hand-derived edge number counted from the enabling reset.
module tb_tx_skp_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] in_data;
  logic [3:0]  in_datak;
  logic        in_valid;
  logic        in_eop;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_datak;
  logic        out_valid;
  logic        skp_sent;
  logic        skp_overflow;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  tx_skp_scheduler #(
    .SKP_INTERVAL_BEATS(8),
    .MAX_PENDING       (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .in_data     (in_data),
    .in_datak    (in_datak),
    .in_valid    (in_valid),
    .in_eop      (in_eop),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_datak   (out_datak),
    .out_valid   (out_valid),
    .skp_sent    (skp_sent),
    .skp_overflow(skp_overflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [3:0] dk, input logic e);
    in_valid = v;
    in_data  = d;
    in_datak = dk;
    in_eop   = e;
    #1;
  endtask

  // kind: 0 = idle, 1 = passthrough beat, 2 = SKP ordered set
  task automatic checkBeat(input string tag, input int kind, input logic [31:0] d, input logic [3:0] dk);
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'(kind != 0));
    checkOutput({tag, ".sent"}, 32'(skp_sent), 32'(kind == 2));
    if (kind == 1) begin
      checkOutput({tag, ".data"}, out_data, d);
      checkOutput({tag, ".datak"}, 32'(out_datak), 32'(dk));
    end else if (kind == 2) begin
      checkOutput({tag, ".skpdata"}, out_data, 32'h1C1C1CBC);
      checkOutput({tag, ".skpdatak"}, 32'(out_datak), 32'hF);
    end
  endtask

  task automatic startScenario();
    reset_n = 1'b0;
    enable  = 1'b0;
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0);
    step();
    reset_n = 1'b1;
    enable  = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0);
    step();
    step();
    checkOutput("rst.data", out_data, 32'h0);
    checkOutput("rst.datak", 32'(out_datak), 32'h0);
    checkOutput("rst.valid", 32'(out_valid), 32'h0);
    checkOutput("rst.sent", 32'(skp_sent), 32'h0);
    checkOutput("rst.ovf", 32'(skp_overflow), 32'h0);
    checkOutput("rst.ready", 32'(in_ready), 32'h1);

    // Idle link: SKP after edges 9 and 17.
    startScenario();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step();
      checkBeat($sformatf("s1.e%0d", k), (k == 9 || k == 17) ? 2 : 0, 32'h0, 4'h0);
      checkOutput($sformatf("s1.e%0d.ovf", k), 32'(skp_overflow), 32'h0);
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b0);
      checkOutput($sformatf("s1.e%0d.ready", k), 32'(in_ready), 32'(!(k == 8 || k == 16)));
    end

    // 10-beat packet in clocks 5..14; the tick at edge 8 is held until after eop.
    startScenario();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      int n;
      step();
      checkBeat($sformatf("s2.e%0d", k), (k >= 5 && k <= 14) ? 1 : (k == 15) ? 2 : 0,
                32'hA000_0000 + 32'(k - 5), (k == 5) ? 4'h1 : 4'h0);
      n = k + 1;
      if (n >= 5 && n <= 14)
        applyStimulus(1'b1, 32'hA000_0000 + 32'(n - 5), (n == 5) ? 4'h1 : 4'h0, n == 14);
      else
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b0);
      if (k <= 15)
        checkOutput($sformatf("s2.e%0d.ready", k), 32'(in_ready), 32'(k != 14));
    end

    // 30-beat packet in clocks 5..34: pending saturates, overflow on the 4th tick.
    startScenario();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0);
    for (int k = 1; k <= 38; k++) begin
      int n;
      step();
      checkBeat($sformatf("s3.e%0d", k), (k >= 5 && k <= 34) ? 1 : (k >= 35 && k <= 37) ? 2 : 0,
                32'hB000_0000 + 32'(k - 5), 4'h0);
      checkOutput($sformatf("s3.e%0d.ovf", k), 32'(skp_overflow), 32'(k == 32));
      n = k + 1;
      if (n >= 5 && n <= 34)
        applyStimulus(1'b1, 32'hB000_0000 + 32'(n - 5), 4'h0, n == 34);
      else
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b0);
      checkOutput($sformatf("s3.e%0d.ready", k), 32'(in_ready), 32'(!(k >= 34 && k <= 36)));
    end

    // Packet ends at clock 15 so the insertion in clock 16 coincides with a tick.
    startScenario();
    applyStimulus(1'b1, 32'hC000_0000, 4'h0, 1'b0);
    for (int k = 1; k <= 23; k++) begin
      int n;
      step();
      checkBeat($sformatf("s4.e%0d", k), (k <= 15) ? 1 : (k == 16 || k == 17) ? 2 : 0,
                32'hC000_0000 + 32'(k - 1), 4'h0);
      checkOutput($sformatf("s4.e%0d.ovf", k), 32'(skp_overflow), 32'h0);
      n = k + 1;
      if (n <= 15)
        applyStimulus(1'b1, 32'hC000_0000 + 32'(n - 1), 4'h0, n == 15);
      else
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b0);
      checkOutput($sformatf("s4.e%0d.ready", k), 32'(in_ready), 32'(!(k == 15 || k == 16)));
    end

    // enable low for clocks 17..24 with pending = 2; first SKP 8 clocks after re-enable.
    startScenario();
    applyStimulus(1'b1, 32'hD000_0000, 4'h0, 1'b0);
    for (int k = 1; k <= 34; k++) begin
      int n;
      int kind;
      logic [31:0] d;
      logic [3:0]  dk;
      step();
      kind = (k <= 18 || k == 20 || k == 21) ? 1 : (k == 33) ? 2 : 0;
      d    = (k <= 18) ? 32'hD000_0000 + 32'(k - 1) : 32'hE000_0000 + 32'(k);
      dk   = (k <= 18) ? 4'h0 : 4'h2;
      checkBeat($sformatf("s5.e%0d", k), kind, d, dk);
      checkOutput($sformatf("s5.e%0d.ovf", k), 32'(skp_overflow), 32'h0);
      n = k + 1;
      enable = !(n >= 17 && n <= 24);
      if (n <= 18)
        applyStimulus(1'b1, 32'hD000_0000 + 32'(n - 1), 4'h0, n == 18);
      else if (n == 20 || n == 21)
        applyStimulus(1'b1, 32'hE000_0000 + 32'(n), 4'h2, 1'b1);
      else
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b0);
      checkOutput($sformatf("s5.e%0d.ready", k), 32'(in_ready), 32'(k != 32));
    end

    // Reset at clock 10 mid-packet with pending = 1; a single-beat packet follows at once.
    startScenario();
    applyStimulus(1'b1, 32'hF100_0000, 4'h0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      int n;
      step();
      if (k == 10) begin
        checkOutput("s6.rst.data", out_data, 32'h0);
        checkOutput("s6.rst.datak", 32'(out_datak), 32'h0);
        checkOutput("s6.rst.valid", 32'(out_valid), 32'h0);
        checkOutput("s6.rst.sent", 32'(skp_sent), 32'h0);
        checkOutput("s6.rst.ovf", 32'(skp_overflow), 32'h0);
      end else if (k == 11) begin
        checkBeat("s6.e11", 1, 32'hF200_0000, 4'h3);
      end else begin
        checkBeat($sformatf("s6.e%0d", k), (k <= 9) ? 1 : 0, 32'hF100_0000 + 32'(k - 1), 4'h0);
      end
      n = k + 1;
      reset_n = (n != 10);
      if (n <= 10)
        applyStimulus(1'b1, 32'hF100_0000 + 32'(n - 1), 4'h0, 1'b0);
      else if (n == 11)
        applyStimulus(1'b1, 32'hF200_0000, 4'h3, 1'b1);
      else
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b0);
      checkOutput($sformatf("s6.e%0d.ready", k), 32'(in_ready), 32'h1);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
